// File: rtl/vc_credit_allocator.sv
// vc_credit_allocator: NIC-side VC allocator and per-VC credit tracker for the
// link into the router input port. Round-robin VC grant within the requested
// vnet, per-VC credit counters and busy flags driven by router credit/free.
// Optional protocol-error checking is built when VC_CREDIT_CHECK_EN is defined;
// otherwise err_o is tied low.
module vc_credit_allocator #(
  parameter int unsigned N_OF_VNET      = 3,
  parameter int unsigned N_OF_VC        = 2,
  parameter int unsigned N_TOT_OF_VC    = 6,
  parameter int unsigned N_BITS_VNET    = 2,
  parameter int unsigned N_BITS_POINTER = 3,
  parameter int unsigned BUFFER_DEPTH   = 8,
  parameter int unsigned N_BITS_CREDIT  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_i,
  input  logic [N_BITS_VNET-1:0]    req_vnet_i,
  output logic                      gnt_o,
  output logic [N_BITS_POINTER-1:0] gnt_vc_o,
  input  logic                      flit_sent_i,
  input  logic [N_BITS_POINTER-1:0] flit_vc_i,
  input  logic [N_TOT_OF_VC-1:0]    credit_signal_i,
  input  logic [N_TOT_OF_VC-1:0]    free_signal_i,
  output logic [N_TOT_OF_VC-1:0]    credit_avail_o,
  output logic [N_TOT_OF_VC-1:0]    vc_busy_o,
  output logic                      err_o
);

  localparam int unsigned N_BITS_LVC = (N_OF_VC > 1) ? $clog2(N_OF_VC) : 1;
  localparam logic [N_BITS_CREDIT-1:0] CREDIT_MAX = N_BITS_CREDIT'(BUFFER_DEPTH);
  localparam logic [N_BITS_LVC-1:0]    PTR_INIT   = N_BITS_LVC'(N_OF_VC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e                    state_q;
  logic                      gnt_q;
  logic [N_BITS_POINTER-1:0] gnt_vc_q;
  logic [N_BITS_LVC-1:0]     ptr_q [N_OF_VNET];
  logic [N_TOT_OF_VC-1:0]    busy_q, busy_d;
  logic [N_TOT_OF_VC-1:0]    avail_q, avail_d;
  logic [N_BITS_CREDIT-1:0]  credit_q [N_TOT_OF_VC];
  logic [N_BITS_CREDIT-1:0]  credit_d [N_TOT_OF_VC];

  logic                      pick_found_c;
  logic [N_BITS_LVC-1:0]     pick_lvc_c;
  logic [N_BITS_POINTER-1:0] pick_vc_c;
  logic                      grant_c;
  logic [N_TOT_OF_VC-1:0]    grant_mask_c;
  logic                      flit_ok_c;
  logic [N_TOT_OF_VC-1:0]    dec_c;

  // Round-robin search for the first non-busy VC after the vnet's pointer
  always_comb begin
    int unsigned lvc;
    int unsigned gvc;
    pick_found_c = 1'b0;
    pick_lvc_c   = '0;
    pick_vc_c    = '0;
    lvc          = 0;
    gvc          = 0;
    if (32'(req_vnet_i) < N_OF_VNET) begin
      for (int unsigned k = 1; k <= N_OF_VC; k++) begin
        lvc = (32'(ptr_q[req_vnet_i]) + k) % N_OF_VC;
        gvc = 32'(req_vnet_i) * N_OF_VC + lvc;
        if (!pick_found_c && !busy_q[N_BITS_POINTER'(gvc)]) begin
          pick_found_c = 1'b1;
          pick_lvc_c   = N_BITS_LVC'(lvc);
          pick_vc_c    = N_BITS_POINTER'(gvc);
        end
      end
    end
    grant_c      = (state_q == IDLE) && req_i && pick_found_c;
    grant_mask_c = grant_c ? (N_TOT_OF_VC'(1) << pick_vc_c) : '0;
  end

  // Decode the sent flit; out-of-range VC ids are dropped
  always_comb begin
    flit_ok_c = flit_sent_i && (32'(flit_vc_i) < N_TOT_OF_VC);
    dec_c     = '0;
    for (int i = 0; i < int'(N_TOT_OF_VC); i++) begin
      dec_c[i] = flit_ok_c && (flit_vc_i == N_BITS_POINTER'(i));
    end
  end

  // Busy/credit next state: free reloads, otherwise saturating +1/-1
  always_comb begin
    busy_d = (busy_q & ~free_signal_i) | grant_mask_c;
    for (int i = 0; i < int'(N_TOT_OF_VC); i++) begin
      credit_d[i] = credit_q[i];
      if (free_signal_i[i] && busy_q[i]) begin
        credit_d[i] = CREDIT_MAX;
      end else if (credit_signal_i[i] && !dec_c[i] && (credit_q[i] != CREDIT_MAX)) begin
        credit_d[i] = credit_q[i] + N_BITS_CREDIT'(1);
      end else if (dec_c[i] && !credit_signal_i[i] && (credit_q[i] != '0)) begin
        credit_d[i] = credit_q[i] - N_BITS_CREDIT'(1);
      end
      avail_d[i] = (credit_d[i] != '0);
    end
  end

  // Grant FSM plus all VC state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      gnt_vc_q <= '0;
      busy_q   <= '0;
      avail_q  <= '1;
      for (int v = 0; v < int'(N_OF_VNET); v++) ptr_q[v] <= PTR_INIT;
      for (int i = 0; i < int'(N_TOT_OF_VC); i++) credit_q[i] <= CREDIT_MAX;
    end else begin
      busy_q   <= busy_d;
      avail_q  <= avail_d;
      credit_q <= credit_d;
      case (state_q)
        IDLE: begin
          gnt_q <= 1'b0;
          if (grant_c) begin
            gnt_q               <= 1'b1;
            gnt_vc_q            <= pick_vc_c;
            ptr_q[req_vnet_i]   <= pick_lvc_c;
            state_q             <= GRANT;
          end
        end
        GRANT: begin
          gnt_q   <= 1'b0;
          state_q <= req_i ? HOLD : IDLE;
        end
        HOLD: begin
          gnt_q <= 1'b0;
          if (!req_i) state_q <= IDLE;
        end
        default: begin
          gnt_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt_o          = gnt_q;
  assign gnt_vc_o       = gnt_vc_q;
  assign vc_busy_o      = busy_q;
  assign credit_avail_o = avail_q;

`ifdef VC_CREDIT_CHECK_EN
  logic err_q;
  logic err_event_c;

  // Collect every protocol-error event of this cycle
  always_comb begin
    err_event_c = 1'b0;
    if (flit_sent_i && !flit_ok_c) err_event_c = 1'b1;
    if (flit_ok_c && !busy_q[flit_vc_i]) err_event_c = 1'b1;
    for (int i = 0; i < int'(N_TOT_OF_VC); i++) begin
      if (free_signal_i[i] && !busy_q[i]) begin
        err_event_c = 1'b1;
      end else if (!free_signal_i[i]) begin
        if (credit_signal_i[i] && !dec_c[i] && (credit_q[i] == CREDIT_MAX)) err_event_c = 1'b1;
        if (dec_c[i] && !credit_signal_i[i] && (credit_q[i] == '0)) err_event_c = 1'b1;
      end
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | err_event_c;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_vc_credit_allocator.sv
// Scoreboard bench for vc_credit_allocator: grant expectations are queued by the
// stimulus and consumed by a negedge monitor; status outputs checked directly.
module tb_vc_credit_allocator;

`ifdef VC_CREDIT_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_i;
  logic [1:0] req_vnet_i;
  logic       gnt_o;
  logic [2:0] gnt_vc_o;
  logic       flit_sent_i;
  logic [2:0] flit_vc_i;
  logic [5:0] credit_signal_i;
  logic [5:0] free_signal_i;
  logic [5:0] credit_avail_o;
  logic [5:0] vc_busy_o;
  logic       err_o;

  int vectors     = 0;
  int miscompares = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  vc_credit_allocator dut (
    .clk             (clk),
    .rst             (rst),
    .req_i           (req_i),
    .req_vnet_i      (req_vnet_i),
    .gnt_o           (gnt_o),
    .gnt_vc_o        (gnt_vc_o),
    .flit_sent_i     (flit_sent_i),
    .flit_vc_i       (flit_vc_i),
    .credit_signal_i (credit_signal_i),
    .free_signal_i   (free_signal_i),
    .credit_avail_o  (credit_avail_o),
    .vc_busy_o       (vc_busy_o),
    .err_o           (err_o)
  );

  // Monitor: every grant pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (gnt_o === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_grant: got vc %0d, expected no grant", gnt_vc_o);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (32'(gnt_vc_o) !== 32'(e)) begin
          miscompares++;
          $display("FAIL grant_vc: got %0d, expected %0d", gnt_vc_o, e);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    chk("pending_grants", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rst             = 1'b1;
    req_i           = 1'b0;
    req_vnet_i      = 2'd0;
    flit_sent_i     = 1'b0;
    flit_vc_i       = 3'd0;
    credit_signal_i = '0;
    free_signal_i   = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic do_req(input logic [1:0] vnet, input int exp_vc, input int hold);
    exp_q.push_back(exp_vc);
    req_i      = 1'b1;
    req_vnet_i = vnet;
    tick;
    chk("gnt_pulse", 32'(gnt_o), 32'd1);
    for (int h = 0; h < hold; h++) begin
      tick;
      chk("gnt_hold_low", 32'(gnt_o), 32'd0);
    end
    req_i = 1'b0;
    tick;
    chk("gnt_after_low", 32'(gnt_o), 32'd0);
  endtask

  task automatic do_req_none(input logic [1:0] vnet);
    req_i      = 1'b1;
    req_vnet_i = vnet;
    tick;
    chk("no_gnt", 32'(gnt_o), 32'd0);
    req_i = 1'b0;
    tick;
  endtask

  task automatic send_flits(input logic [2:0] vc, input int n);
    flit_sent_i = 1'b1;
    flit_vc_i   = vc;
    repeat (n) tick;
    flit_sent_i = 1'b0;
  endtask

  task automatic do_free(input logic [5:0] mask);
    free_signal_i = mask;
    tick;
    free_signal_i = '0;
  endtask

  initial begin
    // Reset state
    do_reset;
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_gnt_vc", 32'(gnt_vc_o), 32'd0);
    chk("rst_busy", 32'(vc_busy_o), 32'h00);
    chk("rst_avail", 32'(credit_avail_o), 32'h3f);
    chk("rst_err", 32'(err_o), 32'd0);

    // vnet 1: VC 2, then VC 3, then none
    do_req(2'd1, 2, 0);
    chk("busy_vc2", 32'(vc_busy_o), 32'h04);
    do_req(2'd1, 3, 0);
    chk("busy_vc23", 32'(vc_busy_o), 32'h0c);
    do_req_none(2'd1);
    chk("busy_full", 32'(vc_busy_o), 32'h0c);

    // Free VC 2 while requesting: grant only from the following cycle
    req_i         = 1'b1;
    req_vnet_i    = 2'd1;
    free_signal_i = 6'b000100;
    tick;
    free_signal_i = '0;
    chk("no_gnt_free_cycle", 32'(gnt_o), 32'd0);
    chk("busy_after_free", 32'(vc_busy_o), 32'h08);
    exp_q.push_back(2);
    tick;
    chk("gnt_after_free", 32'(gnt_o), 32'd1);
    chk("busy_regrant", 32'(vc_busy_o), 32'h0c);
    req_i = 1'b0;
    tick;
    chk("err_clean_vnet1", 32'(err_o), 32'd0);

    // Credit drain, underflow and refill on VC 0
    do_reset;
    do_req(2'd0, 0, 0);
    send_flits(3'd0, 7);
    chk("avail_after7", 32'(credit_avail_o), 32'h3f);
    send_flits(3'd0, 1);
    chk("avail_after8", 32'(credit_avail_o), 32'h3e);
    chk("err_after8", 32'(err_o), 32'd0);
    send_flits(3'd0, 1);
    chk("avail_underflow", 32'(credit_avail_o), 32'h3e);
    chk("err_underflow", 32'(err_o), 32'(CHK));
    tick;
    chk("err_sticky", 32'(err_o), 32'(CHK));
    credit_signal_i = 6'b000001;
    tick;
    credit_signal_i = '0;
    chk("avail_refill", 32'(credit_avail_o), 32'h3f);
    chk("err_still", 32'(err_o), 32'(CHK));

    // Simultaneous +1/-1 on VC 4 at full credit leaves it at 8
    do_reset;
    do_req(2'd2, 4, 0);
    flit_sent_i     = 1'b1;
    flit_vc_i       = 3'd4;
    credit_signal_i = 6'b010000;
    tick;
    flit_sent_i     = 1'b0;
    credit_signal_i = '0;
    chk("err_simul", 32'(err_o), 32'd0);
    chk("avail_simul", 32'(credit_avail_o), 32'h3f);
    send_flits(3'd4, 7);
    chk("avail_vc4_7", 32'(credit_avail_o), 32'h3f);
    send_flits(3'd4, 1);
    chk("avail_vc4_8", 32'(credit_avail_o), 32'h2f);
    chk("err_vc4", 32'(err_o), 32'd0);

    // Round-robin on vnet 0 with frees in between; last request held
    do_reset;
    do_req(2'd0, 0, 0);
    do_free(6'b000001);
    do_req(2'd0, 1, 0);
    do_free(6'b000010);
    do_req(2'd0, 0, 0);
    do_free(6'b000001);
    do_req(2'd0, 1, 3);
    chk("busy_rr", 32'(vc_busy_o), 32'h02);
    do_req(2'd0, 0, 0);
    chk("busy_rr2", 32'(vc_busy_o), 32'h03);
    chk("err_rr", 32'(err_o), 32'd0);

    // Reset while in GRANT aborts the grant
    do_reset;
    exp_q.push_back(4);
    req_i      = 1'b1;
    req_vnet_i = 2'd2;
    tick;
    chk("gnt_before_rst", 32'(gnt_o), 32'd1);
    rst = 1'b1;
    tick;
    chk("gnt_after_rst", 32'(gnt_o), 32'd0);
    chk("busy_after_rst", 32'(vc_busy_o), 32'h00);
    rst   = 1'b0;
    req_i = 1'b0;
    tick;

    // Out-of-range flit VC is ignored
    send_flits(3'd7, 1);
    chk("err_bad_vc", 32'(err_o), 32'(CHK));
    chk("avail_bad_vc", 32'(credit_avail_o), 32'h3f);

    // Free on an idle VC changes nothing
    do_reset;
    do_free(6'b000001);
    chk("err_bad_free", 32'(err_o), 32'(CHK));
    chk("busy_bad_free", 32'(vc_busy_o), 32'h00);
    chk("avail_bad_free", 32'(credit_avail_o), 32'h3f);

    tick;
    chk("pending_grants_end", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
